// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: ID/EX pipeline register with EX operand-forwarding selects and load-use hazard detection
module id_ex_fwd_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_use_pc,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              load_use_hazard
);
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              use_pc;
    logic              use_imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_t;
  ex_t st_d, st_q;
  logic exmem_a, exmem_b, memwb_a, memwb_b;
  always_comb
    st_d = flush ? '0 : stall ? st_q : '{
      valid:     id_valid,
      reg_write: id_reg_write & id_valid,
      mem_read:  id_mem_read & id_valid,
      use_pc:    id_use_pc,
      use_imm:   id_use_imm,
      pc:        id_pc,
      imm:       id_imm,
      rs1_data:  id_rs1_data,
      rs2_data:  id_rs2_data,
      rs1:       id_rs1,
      rs2:       id_rs2,
      rd:        id_rd
    };
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= '0;
    else st_q <= st_d;
  assign ex_valid     = st_q.valid;
  assign ex_pc        = st_q.pc;
  assign ex_imm       = st_q.imm;
  assign ex_rs1_data  = st_q.rs1_data;
  assign ex_rs2_data  = st_q.rs2_data;
  assign ex_rs1       = st_q.rs1;
  assign ex_rs2       = st_q.rs2;
  assign ex_rd        = st_q.rd;
  assign ex_reg_write = st_q.reg_write;
  assign ex_mem_read  = st_q.mem_read;
  always_comb begin
    exmem_a   = exmem_reg_write && exmem_rd != '0 && exmem_rd == st_q.rs1;
    exmem_b   = exmem_reg_write && exmem_rd != '0 && exmem_rd == st_q.rs2;
    memwb_a   = memwb_reg_write && memwb_rd != '0 && memwb_rd == st_q.rs1;
    memwb_b   = memwb_reg_write && memwb_rd != '0 && memwb_rd == st_q.rs2;
    fwd_a_sel = !st_q.valid ? 2'b00 : st_q.use_pc  ? 2'b11 : exmem_a ? 2'b10 : memwb_a ? 2'b01 : 2'b00;
    fwd_b_sel = !st_q.valid ? 2'b00 : st_q.use_imm ? 2'b11 : exmem_b ? 2'b10 : memwb_b ? 2'b01 : 2'b00;
    load_use_hazard = st_q.valid && st_q.mem_read && st_q.rd != '0 && id_valid &&
                      (st_q.rd == id_rs1 || st_q.rd == id_rs2);
  end
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb_id_ex_fwd_stage: scoreboard bench for id_ex_fwd_stage with directed cases and randomized traffic
module tb_id_ex_fwd_stage;
  logic        clk = 0, rst_n = 0, stall = 0, flush = 0, id_valid = 0;
  logic [63:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
  logic        id_reg_write = 0, id_mem_read = 0, id_use_pc = 0, id_use_imm = 0;
  logic        exmem_reg_write = 0, memwb_reg_write = 0;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
  logic [63:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  int vectors = 0, miscompares = 0;
  typedef struct packed {
    logic v, rw, mr, upc, uimm;
    logic [63:0] pc, imm, d1, d2;
    logic [4:0] rs1, rs2, rd;
  } st_t;
  typedef struct packed {
    st_t s;
    logic [1:0] a, b;
    logic h;
  } exp_t;
  st_t m = '0;
  exp_t q[$];
  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_use_pc(id_use_pc),
    .id_use_imm(id_use_imm), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .load_use_hazard(load_use_hazard)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Which operand source the EX stage should read: the youngest in-flight writer of the register wins.
  function automatic logic [1:0] src(input st_t s, input logic use_alt, input logic [4:0] r);
    if (!s.v) return 2'd0;
    if (use_alt) return 2'd3;
    if (r == 0) return 2'd0;
    if (exmem_reg_write && exmem_rd == r) return 2'd2;
    if (memwb_reg_write && memwb_rd == r) return 2'd1;
    return 2'd0;
  endfunction
  task automatic step();
    exp_t e;
    if (!rst_n) m = '0;
    else begin
      if (flush) m = '0;
      else if (!stall) m = '{v: id_valid, rw: id_reg_write && id_valid, mr: id_mem_read && id_valid,
                             upc: id_use_pc, uimm: id_use_imm, pc: id_pc, imm: id_imm,
                             d1: id_rs1_data, d2: id_rs2_data, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
      e.s = m;
      e.a = src(m, m.upc, m.rs1);
      e.b = src(m, m.uimm, m.rs2);
      e.h = m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", 64'(ex_valid), 64'(e.s.v));
      chk("ex_reg_write", 64'(ex_reg_write), 64'(e.s.rw));
      chk("ex_mem_read", 64'(ex_mem_read), 64'(e.s.mr));
      chk("ex_pc", ex_pc, e.s.pc);
      chk("ex_imm", ex_imm, e.s.imm);
      chk("ex_rs1_data", ex_rs1_data, e.s.d1);
      chk("ex_rs2_data", ex_rs2_data, e.s.d2);
      chk("ex_rs1", 64'(ex_rs1), 64'(e.s.rs1));
      chk("ex_rs2", 64'(ex_rs2), 64'(e.s.rs2));
      chk("ex_rd", 64'(ex_rd), 64'(e.s.rd));
      chk("fwd_a_sel", 64'(fwd_a_sel), 64'(e.a));
      chk("fwd_b_sel", 64'(fwd_b_sel), 64'(e.b));
      chk("load_use_hazard", 64'(load_use_hazard), 64'(e.h));
    end
  end
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(ex_valid), 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_rs1_data"}, ex_rs1_data, 0);
    chk({tag, "_rd"}, 64'(ex_rd), 0);
    chk({tag, "_mem_read"}, 64'(ex_mem_read), 0);
    chk({tag, "_sel_a"}, 64'(fwd_a_sel), 0);
    chk({tag, "_sel_b"}, 64'(fwd_b_sel), 0);
    chk({tag, "_hazard"}, 64'(load_use_hazard), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    id_valid = 1; id_rs1 = 3; id_rs1_data = 64'hDEAD; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
    id_pc = 64'h1000;
    step();
    chk("pipe_rs1", 64'(ex_rs1), 3);
    chk("pipe_rs1_data", ex_rs1_data, 64'hDEAD);
    chk("pipe_valid", 64'(ex_valid), 1);
    id_rs1 = 0; id_rs2 = 7; id_mem_read = 0;
    #1 chk("lu_hazard", 64'(load_use_hazard), 1);
    flush = 1;
    step();
    chk("lu_flush_valid", 64'(ex_valid), 0);
    chk("lu_flush_hazard", 64'(load_use_hazard), 0);
    flush = 0; id_rs1 = 5; id_rs2 = 0; id_rd = 9;
    step();
    stall = 1; exmem_rd = 5; exmem_reg_write = 1; memwb_rd = 5; memwb_reg_write = 1;
    #1 chk("prio_exmem", 64'(fwd_a_sel), 2'b10);
    exmem_reg_write = 0;
    #1 chk("prio_memwb", 64'(fwd_a_sel), 2'b01);
    exmem_rd = 0; exmem_reg_write = 1;
    #1 chk("x0_no_fwd", 64'(fwd_b_sel), 2'b00);
    step();
    stall = 0; id_use_imm = 1;
    step();
    chk("use_imm", 64'(fwd_b_sel), 2'b11);
    stall = 1; flush = 1;
    step();
    chk("stall_flush_valid", 64'(ex_valid), 0);
    stall = 0; flush = 0; id_pc = 64'hCAFE_0000_1234; id_use_imm = 0;
    step();
    stall = 1; id_pc = 64'h0BAD; id_valid = 0;
    repeat (3) step();
    chk("stall3_pc", ex_pc, 64'hCAFE_0000_1234);
    chk("stall3_valid", 64'(ex_valid), 1);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    step();
    stall = 0; rst_n = 1; id_valid = 1; id_pc = 64'h2000;
    step();
    chk("post_rst_load", ex_pc, 64'h2000);
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_pc = {$urandom, $urandom};
      id_imm = {$urandom, $urandom};
      id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom};
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_reg_write = 1'($urandom);
      id_mem_read = 1'($urandom);
      id_use_pc = ($urandom_range(0, 3) == 0);
      id_use_imm = ($urandom_range(0, 3) == 0);
      exmem_rd = 5'($urandom_range(0, 7));
      memwb_rd = 5'($urandom_range(0, 7));
      exmem_reg_write = 1'($urandom);
      memwb_reg_write = 1'($urandom);
      step();
    end
    step();
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
